mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//  Multiply/divide sequencer for the P6 pipeline, E stage. Accepts 4-bit MDU op codes from the decoder,
//  owns HI/LO, models fixed mult/div latency with a busy counter, and drives the D-stage stall.
//  Serves mf*/mt* without delay when idle. Sits beside the ALU; mf data feeds the E->M result mux.
// PARAMETERS
//  MULT_LAT  5   busy cycles for mult/multu (>=1)
//  DIV_LAT   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   sole clock; rising edge
//  reset      in   1   synchronous, active-low: reset==0 at a rising clk edge clears all state
//  op_i       in   4   MDU op: 0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
//  op_valid   in   1   E-stage instr is real (0 for bubble); op_i ignored when 0
//  a_i        in   32  rs operand (forwarded)
//  b_i        in   32  rt operand (forwarded)
//  d_uses_mdu in   1   D-stage instr has nonzero op_i
//  start      out  1   comb; accepted mult/multu/div/divu this cycle
//  busy       out  1   registered; operation in flight
//  stall      out  1   comb; = d_uses_mdu & (start | busy)
//  hi         out  32  architectural HI
//  lo         out  32  architectural LO
//  mf_data    out  32  comb; hi when op_i==5, lo when op_i==6, else 0
// BEHAVIOUR
//  Reset: cnt=0, busy=0, hi=lo=0, pending regs=0. start/stall/mf_data follow inputs (0 when op_valid=0).
//  FSM: IDLE (cnt==0) / RUN (cnt!=0). busy = (cnt!=0).
//  IDLE, op_valid & op in 1..4: start=1. Edge: compute result into hi_p/lo_p, load cnt = MULT_LAT or DIV_LAT.
//  RUN: each edge cnt<=cnt-1. On the edge where cnt==1: hi<=hi_p, lo<=lo_p, next state IDLE.
//  Timing: start in cycle t -> busy=1 in cycles t+1..t+LAT -> new hi/lo visible in cycle t+LAT+1.
//  mult: {hi,lo}=signed 64-bit product. multu: unsigned 64-bit product.
//  div: lo=quotient truncated toward zero; hi=remainder with dividend's sign.
//  divu: unsigned quotient/remainder.
//  Divide by zero: op runs full DIV_LAT; hi/lo left unchanged at commit.
//  div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  mthi/mtlo (7/8), op_valid, IDLE: hi (or lo) <= a_i at edge. Takes effect next cycle, no busy.
//  mfhi/mflo: mf_data comb from current hi/lo. A mthi one cycle earlier is visible; no internal bypass.
//  Any op_valid op while busy=1: stall guarantees this never occurs.
//    RTL ignores it (no start, no write); assertion fires.
//  mt* in the same cycle as a commit edge cannot occur (busy blocks it).
//  reset==0 mid-RUN: pending result discarded, cnt=0, hi=lo=0 at that edge.
//  stall holds D; E receives bubbles (op_valid=0) while stalled.
// STRUCTURE
//  Shared header mdu_defs.vh: `define codes MDU_NONE..MDU_MTLO (0..8), shared with the Controller.
//  One sub-module, mdu_arith (comb): op, a, b -> {hi_r, lo_r, dz}.
//    Holds all signed/unsigned mult/div math, incl. the divide-by-zero flag.
//  mdu_seq keeps only the counter, FSM, HI/LO and pending registers.
// TESTING
//  reset=0 two cycles -> hi=lo=0, busy=0. Then op=7 a=0x1234 -> next cycle hi=0x1234.
//  mult a=0xFFFFFFFE (-2) b=3 at t -> busy t+1..t+5; t+6 hi=0xFFFFFFFF lo=0xFFFFFFFA.
//  multu a=0xFFFFFFFF b=2 -> after 5 busy cycles hi=1, lo=0xFFFFFFFE.
//  div a=0xFFFFFFF9 (-7) b=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    divu a=7 b=0 -> hi/lo unchanged.
//  d_uses_mdu=1 during start cycle and every busy cycle -> stall=1; stall=0 in cycle t+LAT+1.
//    Then mflo -> mf_data=new lo.
//  reset=0 at busy cycle 3 of a div -> busy=0, hi=lo=0 next cycle; no later commit occurs.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// MDU sequencer shared definitions.
// Op codes shared with the controller decode.
package mdu_seq_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic is_arith(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_DIVU);
    endfunction

    function automatic logic is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// MDU sequencer E-stage bus.
// master = pipeline side, slave = mdu_seq.
interface mdu_seq_if;

    logic [3:0]  op_i;
    logic        op_valid;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        d_uses_mdu;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    modport master (
        output op_i, op_valid, a_i, b_i, d_uses_mdu,
        input  start, busy, stall, hi, lo, mf_data
    );

    modport slave (
        input  op_i, op_valid, a_i, b_i, d_uses_mdu,
        output start, busy, stall, hi, lo, mf_data
    );

endinterface

// File: rtl/mdu_arith.sv
// MDU combinational math: mult/multu/div/divu.
// Signed divide works on magnitudes, then fixes signs.
import mdu_seq_pkg::*;

module mdu_arith (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_r,
    output logic [31:0] lo_r,
    output logic        dz
);

    logic        sgn_m;
    logic        sgn_d;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] prod;
    logic [31:0] na;
    logic [31:0] nb;
    logic [31:0] dd;
    logic [31:0] q;
    logic [31:0] r;

    // Compute product or quotient/remainder for the presented op.
    always_comb begin
        sgn_m = (op == MDU_MULT);
        ea    = sgn_m ? {{32{a[31]}}, a} : {32'b0, a};
        eb    = sgn_m ? {{32{b[31]}}, b} : {32'b0, b};
        prod  = ea * eb;
        sgn_d = (op == MDU_DIV);
        na    = (sgn_d & a[31]) ? -a : a;
        nb    = (sgn_d & b[31]) ? -b : b;
        dd    = (nb == 32'd0) ? 32'd1 : nb;
        q     = na / dd;
        r     = na % dd;
        dz    = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
        hi_r  = 32'd0;
        lo_r  = 32'd0;
        unique case (1'b1)
            is_mult(op): begin
                hi_r = prod[63:32];
                lo_r = prod[31:0];
            end
            (op == MDU_DIV) || (op == MDU_DIVU): begin
                lo_r = (sgn_d & (a[31] ^ b[31])) ? -q : q;
                hi_r = (sgn_d & a[31]) ? -r : r;
            end
            default: begin
                hi_r = 32'd0;
                lo_r = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// MDU sequencer: HI/LO owner, fixed-latency busy counter,
// D-stage stall generation.
import mdu_seq_pkg::*;

module mdu_seq #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic     clk,
    input logic     reset,
    mdu_seq_if.slave bus
);

    localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    logic [CW-1:0] cnt;
    logic [0:0]    state;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   hi_p;
    logic [31:0]   lo_p;
    logic          dz_p;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;
    logic          dz;
    logic          busy;
    logic          idle_op;
    logic          start;
    logic          mt_hi;
    logic          mt_lo;
    logic [31:0]   mf;

    mdu_arith u_arith (
        .op   (bus.op_i),
        .a    (bus.a_i),
        .b    (bus.b_i),
        .hi_r (hi_r),
        .lo_r (lo_r),
        .dz   (dz)
    );

    assign state   = (cnt != '0) ? ST_RUN : ST_IDLE;
    assign busy    = (state == ST_RUN);
    assign idle_op = bus.op_valid & ~busy;
    assign start   = idle_op & is_arith(bus.op_i);
    assign mt_hi   = idle_op & (bus.op_i == MDU_MTHI);
    assign mt_lo   = idle_op & (bus.op_i == MDU_MTLO);

    // Move-from data straight off the architectural registers.
    always_comb begin
        mf = 32'd0;
        if (bus.op_valid) begin
            if (bus.op_i == MDU_MFHI)
                mf = hi_q;
            else if (bus.op_i == MDU_MFLO)
                mf = lo_q;
        end
    end

    // Counter/FSM, pending result capture and HI/LO update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
            hi_p <= 32'd0;
            lo_p <= 32'd0;
            dz_p <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hi_p <= hi_r;
                        lo_p <= lo_r;
                        dz_p <= dz;
                        cnt  <= is_mult(bus.op_i) ? CW'(MULT_LAT)
                                                  : CW'(DIV_LAT);
                    end else if (mt_hi) begin
                        hi_q <= bus.a_i;
                    end else if (mt_lo) begin
                        lo_q <= bus.a_i;
                    end
                end
                default: begin
                    assert (!(bus.op_valid && bus.op_i != MDU_NONE));
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1) && !dz_p) begin
                        hi_q <= hi_p;
                        lo_q <= lo_p;
                    end
                end
            endcase
        end
    end

    assign bus.start   = start;
    assign bus.busy    = busy;
    assign bus.stall   = bus.d_uses_mdu & (start | busy);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.mf_data = mf;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a HI/LO result scoreboard.
// Inputs change on negedge; outputs sampled before next posedge.
module tb_mdu_seq;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    logic [63:0] sb_q[$];

    mdu_seq_if bus();

    mdu_seq #(
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic idle_in();
        bus.op_valid = 1'b0;
        bus.op_i     = 4'd0;
        bus.a_i      = 32'd0;
        bus.b_i      = 32'd0;
    endtask

    // Issue one arith op with d_uses_mdu held high, track busy/stall,
    // then pop the scoreboard and compare HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat);
        int n;
        logic [63:0] exp;
        @(negedge clk);
        bus.op_valid   = 1'b1;
        bus.op_i       = op;
        bus.a_i        = a;
        bus.b_i        = b;
        bus.d_uses_mdu = 1'b1;
        #1;
        check({tag, "_start"}, 64'(bus.start), 64'd1);
        check({tag, "_stall0"}, 64'(bus.stall), 64'd1);
        sb_q.push_back({ehi, elo});
        @(negedge clk);
        idle_in();
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (bus.stall !== 1'b1)
                check({tag, "_stall_busy"}, 64'(bus.stall), 64'd1);
            n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_stall_end"}, 64'(bus.stall), 64'd0);
        exp = sb_q.pop_front();
        check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
        bus.d_uses_mdu = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset = 1'b0;
        bus.d_uses_mdu = 1'b0;
        idle_in();
        @(negedge clk);
        @(negedge clk);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_start", 64'(bus.start), 64'd0);
        check("rst_mf", 64'(bus.mf_data), 64'd0);
        reset = 1'b1;

        // mthi then mfhi the very next cycle
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_i     = 4'd7;
        bus.a_i      = 32'h1234;
        @(negedge clk);
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        bus.op_i = 4'd5;
        bus.a_i  = 32'd0;
        #1;
        check("mfhi", 64'(bus.mf_data), 64'h1234);
        @(negedge clk);
        bus.op_i = 4'd8;
        bus.a_i  = 32'h55AA;
        @(negedge clk);
        check("mtlo_lo", 64'(bus.lo), 64'h55AA);
        check("mtlo_hi", 64'(bus.hi), 64'h1234);
        bus.op_valid = 1'b0;
        bus.op_i     = 4'd6;
        #1;
        check("mf_bubble", 64'(bus.mf_data), 64'd0);
        idle_in();

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        bus.op_valid = 1'b1;
        bus.op_i     = 4'd6;
        #1;
        check("mflo_mult", 64'(bus.mf_data), 64'hFFFF_FFFA);
        idle_in();

        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2,
               32'd1, 32'hFFFF_FFFE, 5);
        run_op("mult_min", 4'd1, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'd0, 5);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("divu_z", 4'd4, 32'd7, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 10);
        run_op("div_nb", 4'd3, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD, 10);
        run_op("divu", 4'd4, 32'd100, 32'd7,
               32'd2, 32'd14, 10);
        bus.op_valid = 1'b1;
        bus.op_i     = 4'd6;
        #1;
        check("mflo_divu", 64'(bus.mf_data), 64'd14);
        idle_in();

        // reset during busy cycle 3 of a div
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_i     = 4'd3;
        bus.a_i      = 32'd100;
        bus.b_i      = 32'd7;
        @(negedge clk);
        idle_in();
        check("nd_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (12) @(negedge clk);
        check("no_commit", {bus.hi, bus.lo}, 64'd0);
        check("no_busy", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
